// File: rtl/fpnew_norm_stage.sv
// fpnew_norm_stage: normalisation stage that feeds FP rounding.
// Counts leading zeros, left-normalises or right-shifts denormals, and emits
// the packed {exp, mant} absolute value plus the {round, sticky} pair.
// Elastic valid/ready pipeline of NumPipeRegs stages with synchronous flush.
// Optional: define FPNEW_NORM_SKID_EN to add a 2-entry skid buffer after the
// last stage, which cuts the combinational ready path from out_ready_i.
module fpnew_norm_stage #(
  parameter int unsigned ExpBits     = 8,
  parameter int unsigned ManBits     = 23,
  parameter int unsigned MantWidth   = 27,
  parameter int unsigned ExpWidth    = 10,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [MantWidth-1:0]       mant_i,
  input  logic [ExpWidth-1:0]        exp_i,
  input  logic                       sticky_i,
  input  logic                       sign_i,
  input  logic [TagWidth-1:0]        tag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [ExpBits+ManBits-1:0] abs_value_o,
  output logic [1:0]                 round_sticky_o,
  output logic                       sign_o,
  output logic [TagWidth-1:0]        tag_o,
  output logic                       of_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int unsigned LzcWidth = $clog2(MantWidth + 1);
  localparam int unsigned ShWidth  = ExpWidth + 1;
  localparam int unsigned AbsWidth = ExpBits + ManBits;
  localparam int unsigned PayWidth = AbsWidth + 2 + 1 + TagWidth + 1;
  localparam int unsigned RndPos   = MantWidth - ManBits - 2;

  localparam logic signed [ExpWidth:0] ExpOne = ShWidth'(1);
  localparam logic signed [ExpWidth:0] ExpMax = ShWidth'((1 << ExpBits) - 1);
  localparam logic        [ExpWidth:0] RshMax = ShWidth'(MantWidth + 1);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [LzcWidth-1:0]        w_lzc;
  logic [ExpWidth:0]          w_lzc_ext;
  logic signed [ExpWidth:0]   w_exp_ext;
  logic signed [ExpWidth:0]   w_exp_m1;
  logic signed [ExpWidth:0]   w_exp_norm;
  logic [ExpWidth:0]          w_lsh;
  logic [ExpWidth:0]          w_rsh_raw;
  logic [ExpWidth:0]          w_rsh;
  logic [MantWidth-1:0]       w_norm;
  logic                       w_rloss;
  logic [ManBits-1:0]         w_man;
  logic                       w_round;
  logic                       w_sticky;
  logic                       w_of;
  logic [AbsWidth-1:0]        w_abs;
  logic [1:0]                 w_rs;
  logic [PayWidth-1:0]        w_pay0;

  // Leading-zero count; the highest set bit wins because it is visited last
  always_comb begin
    w_lzc = LzcWidth'(MantWidth);
    for (int i = 0; i < MantWidth; i++) begin
      if (mant_i[i]) w_lzc = LzcWidth'(MantWidth - 1 - i);
    end
  end

  assign w_lzc_ext = ShWidth'(w_lzc);
  assign w_exp_ext = {exp_i[ExpWidth-1], exp_i};
  assign w_exp_m1  = w_exp_ext - ExpOne;

  // Shift selection: left-normalise limited by exponent, or right-shift denormals
  always_comb begin
    w_norm     = '0;
    w_exp_norm = '0;
    w_lsh      = '0;
    w_rsh_raw  = '0;
    w_rsh      = '0;
    w_rloss    = 1'b0;
    if (mant_i == '0) begin
      w_norm = '0;
    end else if (w_exp_ext >= ExpOne) begin
      w_lsh      = (w_lzc_ext < $unsigned(w_exp_m1)) ? w_lzc_ext : $unsigned(w_exp_m1);
      w_norm     = mant_i << w_lsh;
      w_exp_norm = w_exp_ext - $signed(w_lsh);
      // Exponent floor reached before the leading one: result is denormal
      if (!w_norm[MantWidth-1]) w_exp_norm = '0;
    end else begin
      w_rsh_raw = $unsigned(ExpOne - w_exp_ext);
      w_rsh     = (w_rsh_raw > RshMax) ? RshMax : w_rsh_raw;
      w_norm    = mant_i >> w_rsh;
      // Bits that fell off the bottom show up as the difference after shifting back
      w_rloss   = |(mant_i ^ (w_norm << w_rsh));
    end
  end

  assign w_man    = w_norm[MantWidth-2 -: ManBits];
  assign w_round  = w_norm[RndPos];
  assign w_sticky = (|w_norm[RndPos-1:0]) | sticky_i | w_rloss;
  assign w_of     = (w_exp_norm >= ExpMax);
  assign w_abs    = w_of ? {{ExpBits{1'b1}}, {ManBits{1'b0}}}
                         : {w_exp_norm[ExpBits-1:0], w_man};
  assign w_rs     = w_of ? 2'b00 : {w_round, w_sticky};
  assign w_pay0   = {w_of, sign_i, tag_i, w_rs, w_abs};

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  logic                w_valid_last;
  logic [PayWidth-1:0] w_pay_last;
  logic                w_ready_last;
  logic                w_ready_first;
  logic                w_out_valid;
  logic [PayWidth-1:0] w_out_pay;

  if (NumPipeRegs == 0) begin : g_comb
    assign w_valid_last  = in_valid_i & ~flush_i;
    assign w_pay_last    = w_pay0;
    assign w_ready_first = w_ready_last;
  end else begin : g_pipe
    logic [NumPipeRegs:0] w_up_valid;
    logic [NumPipeRegs:0] w_ready;
    logic [PayWidth-1:0]  w_up_pay [NumPipeRegs+1];

    assign w_up_valid[0]         = in_valid_i & ~flush_i;
    assign w_up_pay[0]           = w_pay0;
    assign w_ready[NumPipeRegs]  = w_ready_last;

    for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
      logic                r_valid;
      logic [PayWidth-1:0] r_pay;

      // A stage accepts when empty or when its content leaves this cycle
      assign w_ready[k]      = ~r_valid | w_ready[k+1];
      assign w_up_valid[k+1] = r_valid;
      assign w_up_pay[k+1]   = r_pay;

      // Stage valid bit: flush and reset empty the stage
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid <= 1'b0;
        end else if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_ready[k]) begin
          r_valid <= w_up_valid[k];
        end
      end

      // Stage payload: loads only on capture so outputs hold under backpressure
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_pay <= '0;
        end else if (w_up_valid[k] && w_ready[k] && !flush_i) begin
          r_pay <= w_up_pay[k];
        end
      end
    end

    assign w_valid_last  = w_up_valid[NumPipeRegs];
    assign w_pay_last    = w_up_pay[NumPipeRegs];
    assign w_ready_first = w_ready[0];
  end

  assign in_ready_o = w_ready_first & ~flush_i;

`ifdef FPNEW_NORM_SKID_EN
  // ---------------------------------------------------------------------------
  // Skid buffer: bypassed while empty so latency is unchanged
  // ---------------------------------------------------------------------------
  logic [PayWidth-1:0] r_skid_mem [2];
  logic                r_skid_wp;
  logic                r_skid_rp;
  logic [1:0]          r_skid_cnt;
  logic                w_skid_empty;
  logic                w_skid_push;
  logic                w_skid_pop;

  assign w_skid_empty = (r_skid_cnt == 2'd0);
  // Upstream ready depends only on the registered fill level
  assign w_ready_last = (r_skid_cnt != 2'd2);
  assign w_skid_pop   = ~w_skid_empty & out_ready_i;
  assign w_skid_push  = w_valid_last & w_ready_last & ~(w_skid_empty & out_ready_i);
  assign w_out_valid  = ~w_skid_empty | w_valid_last;
  assign w_out_pay    = w_skid_empty ? w_pay_last : r_skid_mem[r_skid_rp];

  // Skid pointers and fill level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_skid_wp  <= 1'b0;
      r_skid_rp  <= 1'b0;
      r_skid_cnt <= 2'd0;
    end else if (flush_i) begin
      r_skid_wp  <= 1'b0;
      r_skid_rp  <= 1'b0;
      r_skid_cnt <= 2'd0;
    end else begin
      if (w_skid_push) r_skid_wp <= ~r_skid_wp;
      if (w_skid_pop)  r_skid_rp <= ~r_skid_rp;
      if (w_skid_push && !w_skid_pop) begin
        r_skid_cnt <= r_skid_cnt + 2'd1;
      end else if (!w_skid_push && w_skid_pop) begin
        r_skid_cnt <= r_skid_cnt - 2'd1;
      end
    end
  end

  // Skid storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_skid_mem[0] <= '0;
      r_skid_mem[1] <= '0;
    end else if (w_skid_push && !flush_i) begin
      r_skid_mem[r_skid_wp] <= w_pay_last;
    end
  end
`else
  assign w_ready_last = out_ready_i;
  assign w_out_valid  = w_valid_last;
  assign w_out_pay    = w_pay_last;
`endif

  assign out_valid_o = w_out_valid;
  assign {of_o, sign_o, tag_o, round_sticky_o, abs_value_o} = w_out_pay;

endmodule

// File: tb/tb_fpnew_norm_stage.sv
// Directed bench for fpnew_norm_stage: datapath vectors on a 1-stage instance,
// backpressure / flush / reset on a 2-stage instance. Skid-aware when
// FPNEW_NORM_SKID_EN is defined.
module tb_fpnew_norm_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [26:0] mant;
  logic [9:0]  exp_in;
  logic        sticky;
  logic        sign;
  logic [3:0]  tag;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        rdy1, ov1, sg1, of1;
  logic [30:0] abs1;
  logic [1:0]  rs1;
  logic [3:0]  tg1;
  logic        rdy2, ov2, sg2, of2;
  logic [30:0] abs2;
  logic [1:0]  rs2;
  logic [3:0]  tg2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpnew_norm_stage #(.NumPipeRegs(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .mant_i(mant), .exp_i(exp_in), .sticky_i(sticky),
    .sign_i(sign), .tag_i(tag), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .flush_i(flush), .abs_value_o(abs1), .round_sticky_o(rs1), .sign_o(sg1),
    .tag_o(tg1), .of_o(of1), .out_valid_o(ov1), .out_ready_i(out_ready)
  );

  fpnew_norm_stage #(.NumPipeRegs(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .mant_i(mant), .exp_i(exp_in), .sticky_i(sticky),
    .sign_i(sign), .tag_i(tag), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .flush_i(flush), .abs_value_o(abs2), .round_sticky_o(rs2), .sign_o(sg2),
    .tag_o(tg2), .of_o(of2), .out_valid_o(ov2), .out_ready_i(out_ready)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [26:0] m, input int e, input logic st, input logic sg,
                       input logic [3:0] t);
    mant     = m;
    exp_in   = 10'(e);
    sticky   = st;
    sign     = sg;
    tag      = t;
    in_valid = 1'b1;
  endtask

  // Backpressure op k: leading one at the top, exponent 100+k
  function automatic logic [30:0] bp_abs(input int k);
    return 31'((100 + k) << 23);
  endfunction

  // Directed datapath vectors with hand-computed results
  logic [26:0] v_mant [12] = '{27'h4000000, 27'h0000001, 27'h4000000, 27'h4000000,
                               27'h4000007, 27'h4000000, 27'h4000000, 27'h2000000,
                               27'h0000001, 27'h0000000, 27'h4000001, 27'h4000000};
  int          v_exp  [12] = '{127, 127, 0, -30, 127, 255, 254, 255, 5, 50, 0, 127};
  logic        v_st   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
  logic [30:0] v_abs  [12] = '{31'h3F800000, 31'h32800000, 31'h00400000, 31'h00000000,
                               31'h3F800000, 31'h7F800000, 31'h7F000000, 31'h7F000000,
                               31'h00000002, 31'h00000000, 31'h00400000, 31'h3F800000};
  logic [1:0]  v_rs   [12] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00,
                               2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
  logic        v_of   [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

`ifdef FPNEW_NORM_SKID_EN
  localparam int NumBp = 4;
`else
  localparam int NumBp = 3;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mant      = '0;
    exp_in    = '0;
    sticky    = 1'b0;
    sign      = 1'b0;
    tag       = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    // Reset state
    chk("rst_valid", 64'(ov1), 64'h0);
    chk("rst_abs", 64'(abs1), 64'h0);
    chk("rst_rs", 64'(rs1), 64'h0);
    chk("rst_sign", 64'(sg1), 64'h0);
    chk("rst_tag", 64'(tg1), 64'h0);
    chk("rst_of", 64'(of1), 64'h0);
    chk("rst_ready", 64'(rdy1), 64'h1);
    chk("rst_ready2", 64'(rdy2), 64'h1);
    rst_n = 1'b1;
    tick();

    // Datapath vectors, back to back, one-cycle latency on the 1-stage instance
    for (int i = 0; i < 12; i++) begin
      drive(v_mant[i], v_exp[i], v_st[i], 1'(i), 4'(i));
      tick();
      chk($sformatf("dp%0d_valid", i), 64'(ov1), 64'h1);
      chk($sformatf("dp%0d_abs", i), 64'(abs1), 64'(v_abs[i]));
      chk($sformatf("dp%0d_rs", i), 64'(rs1), 64'(v_rs[i]));
      chk($sformatf("dp%0d_of", i), 64'(of1), 64'(v_of[i]));
      chk($sformatf("dp%0d_sign", i), 64'(sg1), 64'(i % 2));
      chk($sformatf("dp%0d_tag", i), 64'(tg1), 64'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("dp_idle", 64'(ov1), 64'h0);
    tick();
    tick();
    chk("dp_idle2", 64'(ov2), 64'h0);

    // Backpressure on the 2-stage instance
    out_ready = 1'b0;
    drive(27'h4000000, 100, 1'b0, 1'b0, 4'd8);
    #1;
    chk("bp_rdy_op0", 64'(rdy2), 64'h1);
    tick();
    drive(27'h4000000, 101, 1'b0, 1'b0, 4'd9);
    #1;
    chk("bp_rdy_op1", 64'(rdy2), 64'h1);
    tick();
    drive(27'h4000000, 102, 1'b0, 1'b0, 4'd10);
    #1;
`ifdef FPNEW_NORM_SKID_EN
    chk("bp_rdy_op2", 64'(rdy2), 64'h1);
    tick();
    drive(27'h4000000, 103, 1'b0, 1'b0, 4'd11);
    #1;
    chk("bp_rdy_op3", 64'(rdy2), 64'h1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_full", 64'(rdy2), 64'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_no_comb", 64'(rdy2), 64'h0);
    out_ready = 1'b0;
    #1;
`else
    chk("bp_full", 64'(rdy2), 64'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", 64'(rdy2), 64'h1);
    out_ready = 1'b0;
    #1;
`endif
    tick();
    chk("bp_hold_valid", 64'(ov2), 64'h1);
    chk("bp_hold_tag", 64'(tg2), 64'h8);
    chk("bp_hold_abs", 64'(abs2), 64'(bp_abs(0)));
    out_ready = 1'b1;
    for (int k = 0; k < NumBp; k++) begin
      #1;
      chk($sformatf("bp_drain%0d_valid", k), 64'(ov2), 64'h1);
      chk($sformatf("bp_drain%0d_tag", k), 64'(tg2), 64'(8 + k));
      chk($sformatf("bp_drain%0d_abs", k), 64'(abs2), 64'(bp_abs(k)));
      tick();
      in_valid = 1'b0;
    end
    #1;
    chk("bp_empty", 64'(ov2), 64'h0);

    // Flush during a stall
    tick();
    out_ready = 1'b0;
    drive(27'h4000000, 100, 1'b0, 1'b0, 4'd8);
    tick();
    drive(27'h4000000, 101, 1'b0, 1'b0, 4'd9);
    tick();
    drive(27'h4000000, 102, 1'b0, 1'b0, 4'd10);
    flush = 1'b1;
    #1;
    chk("fl_rdy_forced", 64'(rdy2), 64'h0);
    chk("fl_pre_valid", 64'(ov2), 64'h1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_cleared", 64'(ov2), 64'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl_no_stale%0d", k), 64'(ov2), 64'h0);
    end
    drive(27'h4000000, 127, 1'b0, 1'b1, 4'hF);
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl_fresh_valid", 64'(ov2), 64'h1);
    chk("fl_fresh_abs", 64'(abs2), 64'h3F800000);
    chk("fl_fresh_tag", 64'(tg2), 64'hF);
    chk("fl_fresh_sign", 64'(sg2), 64'h1);
    tick();

    // Reset while an op is in flight
    drive(27'h4000000, 127, 1'b0, 1'b0, 4'h3);
    tick();
    chk("mr_pre_valid", 64'(ov1), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid1", 64'(ov1), 64'h0);
    chk("mr_valid2", 64'(ov2), 64'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    tick();
    chk("mr_after1", 64'(ov1), 64'h0);
    chk("mr_after2", 64'(ov2), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
